rd_line_collector: RTL and testbench
====================================

// Module: rd_line_collector
// PURPOSE
//  Sits directly downstream of the east edge of the sram_group mem_block chain.
//  Each of the 8 lanes carries one 32-bit segment per read txn; lanes cannot be stalled.
//  Buffers segments per txn slot and assembles them into a 256-bit line.
//  Completed lines drain through an output FIFO with valid/ready to the response path.
// PARAMETERS
//  ENTRIES   8   assembly slots, power of 2; slot = lane_txnid[$clog2(ENTRIES)-1:0]
//  TXNID_W   8   txnid width, >= $clog2(ENTRIES)
//  OUT_DEPTH 4   output FIFO depth, power of 2, >= 2
// PORTS
//  clk          in   1           clock
//  rst          in   1           sync reset, active-high
//  lane_vld     in   8           per-lane segment valid (east_data_out_vld of last block)
//  lane_data    in   8x32        per-lane segment data
//  lane_txnid   in   8xTXNID_W   per-lane txnid from cmd_pld
//  lane_seg     in   8x3         segment index 0..7 within line (cmd_pld byte_sel)
//  out_vld      out  1           assembled line available
//  out_rdy      in   1           consumer accepts line
//  out_data     out  256         line; segment k at bits [32k+31:32k]
//  out_txnid    out  TXNID_W     txnid of line
//  slot_busy    out  ENTRIES     slot holds >=1 segment or is waiting to drain
//  err_dup      out  1           sticky: segment written twice before drain
//  err_busy     out  1           sticky: segment hit slot in DONE state
// BEHAVIOUR
//  Reset: all outputs 0; slots IDLE; masks 0; FIFO empty; err flags cleared only by rst.
//  Slot FSM: IDLE -> FILL on first segment. FILL -> DONE when the 8-bit mask becomes
//   0xFF. DONE -> IDLE on the cycle the slot is pushed into the FIFO.
//  Per cycle, each valid lane writes data[seg] and sets mask[seg] of slot txnid[low].
//   out_txnid field is taken from the writing lane.
//  Several lanes may hit the same slot in one cycle.
//   - Distinct segs: all are written.
//   - Same seg: the highest lane index wins and err_dup is set.
//  Write to a seg whose mask bit is already 1: data overwritten, err_dup set.
//  Write to a DONE slot: dropped, err_busy set, slot unchanged.
//  Completion latency: last segment at edge N; slot DONE at cycle N+1.
//   Push at edge N+1 if FIFO not full; out_vld=1 at cycle N+2 earliest.
//  Push arbitration: at most 1 push per cycle.
//   Lowest-index DONE slot wins (fixed priority).
//   Not-chosen slots stay DONE.
//  FIFO: show-ahead, so out_data/out_txnid are valid whenever out_vld=1.
//   Pop on out_vld&&out_rdy. Push and pop in the same cycle is allowed when full.
//   Pointers wrap modulo OUT_DEPTH; an extra count bit distinguishes full from empty.
//  FIFO full: no push; DONE slots wait and upstream still cannot stall.
//   Issue control guarantees txnids of DONE slots are not reissued (see slot_busy).
//  Slot released (mask cleared, IDLE) on push edge; usable by lane writes from next cycle.
//  slot_busy[s] = (state!=IDLE), registered; drops the cycle after the push.
//  rst asserted mid-operation: partial lines and FIFO contents are discarded with no output.
//  out_vld holds while out_rdy=0. out_data and out_txnid are stable until popped.
// TESTING
//  T1: txnid 3, segs 0..7 on lanes 0..7 in one cycle, data=0x1000+k, out_rdy=1
//   -> out_vld at +2, out_txnid=3, seg k=0x1000+k.
//  T2: txnid 5, segs spread over 4 cycles out of order -> one line at last+2; slot_busy[5]
//   high from first+1 until push+1.
//  T3: slots 1 and 2 complete in the same cycle -> slot1 line, then slot2 line next cycle.
//  T4: out_rdy=0, complete 6 lines (OUT_DEPTH=4) -> 4 queued, 2 slots stay DONE.
//   Then out_rdy=1 -> all 6 in push order, no loss.
//  T5: lanes 2 and 6 both seg 4 of txnid 0 -> lane 6 data kept, err_dup=1 and stays set.
//  T6: write to DONE slot -> err_busy=1, line unchanged.
//   rst mid-fill -> slot_busy=0, out_vld=0 next cycle.

Source files
------------

// File: rtl/rd_line_collector_if.sv
// rd_line_collector_if
//   Bundles the lane-side write bus and the valid/ready line output of
//   rd_line_collector.
//   lane_vld   [8]            per-lane segment valid
//   lane_data  [8][32]        per-lane segment data
//   lane_txnid [8][TXNID_W]   per-lane transaction id
//   lane_seg   [8][3]         per-lane segment index within the line
//   out_vld / out_rdy         line handshake
//   out_data   [256]          assembled line, segment k at bits [32k+31:32k]
//   out_txnid  [TXNID_W]      transaction id of the line
//   master: drives lanes and out_rdy (upstream/consumer side)
//   slave : the collector
interface rd_line_collector_if #(
    parameter int TXNID_W = 8
);
    logic [7:0]                    lane_vld;
    logic [7:0][31:0]              lane_data;
    logic [7:0][TXNID_W-1:0]       lane_txnid;
    logic [7:0][2:0]               lane_seg;
    logic                          out_vld;
    logic                          out_rdy;
    logic [255:0]                  out_data;
    logic [TXNID_W-1:0]            out_txnid;

    modport master (
        output lane_vld, lane_data, lane_txnid, lane_seg, out_rdy,
        input  out_vld, out_data, out_txnid
    );

    modport slave (
        input  lane_vld, lane_data, lane_txnid, lane_seg, out_rdy,
        output out_vld, out_data, out_txnid
    );
endinterface

// File: rtl/rd_line_collector.sv
// rd_line_collector
//   Collects 32-bit read segments arriving on 8 non-stallable lanes into
//   per-transaction assembly slots, and drains each completed 256-bit line
//   through a show-ahead output FIFO with valid/ready.
//   clk        clock
//   rst        synchronous reset, active-high
//   bus        rd_line_collector_if.slave (lanes in, line handshake out)
//   slot_busy  per slot: holds at least one segment or waits to drain
//   err_dup    sticky: a segment was written twice before its line drained
//   err_busy   sticky: a segment hit a slot that was already complete
module rd_line_collector #(
    parameter int ENTRIES   = 8,
    parameter int TXNID_W   = 8,
    parameter int OUT_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    rd_line_collector_if.slave  bus,
    output logic [ENTRIES-1:0]  slot_busy,
    output logic                err_dup,
    output logic                err_busy
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int PTR_W = $clog2(OUT_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } slot_state_t;

    // Assembly slots
    slot_state_t               state_r [ENTRIES];
    logic [7:0]                mask_r  [ENTRIES];
    logic [7:0][31:0]          data_r  [ENTRIES];
    logic [TXNID_W-1:0]        txnid_r [ENTRIES];

    // Output FIFO; count_r carries one extra bit so full and empty differ
    logic [255:0]              fifo_data_r  [OUT_DEPTH];
    logic [TXNID_W-1:0]        fifo_txnid_r [OUT_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_r;
    logic [PTR_W-1:0]          rd_ptr_r;
    logic [PTR_W:0]            count_r;

    logic                      err_dup_r;
    logic                      err_busy_r;

    // Per-cycle lane merge results
    logic [IDX_W-1:0]          lane_slot_s [8];
    logic [7:0]                wr_mask_s   [ENTRIES];
    logic [7:0][31:0]          wr_data_s   [ENTRIES];
    logic [TXNID_W-1:0]        wr_txnid_s  [ENTRIES];
    logic                      dup_s;
    logic                      busy_hit_s;

    logic                      push_hit_s;
    logic [IDX_W-1:0]          push_idx_s;
    logic                      push_s;
    logic                      pop_s;
    logic                      fifo_full_s;

    // Merge all lane writes into per-slot next data; later lanes override earlier ones
    always_comb begin
        dup_s      = 1'b0;
        busy_hit_s = 1'b0;
        for (int l = 0; l < 8; l++) begin
            lane_slot_s[l] = bus.lane_txnid[l][IDX_W-1:0];
        end
        for (int s = 0; s < ENTRIES; s++) begin
            wr_mask_s[s]  = 8'h00;
            wr_data_s[s]  = data_r[s];
            wr_txnid_s[s] = txnid_r[s];
        end
        for (int l = 0; l < 8; l++) begin
            for (int s = 0; s < ENTRIES; s++) begin
                if (bus.lane_vld[l] && (lane_slot_s[l] == IDX_W'(s))) begin
                    if (state_r[s] == S_DONE) begin
                        // Completed slot: the write is dropped, slot untouched
                        busy_hit_s = 1'b1;
                    end else begin
                        // A seg already written this cycle or earlier is a duplicate
                        if (wr_mask_s[s][bus.lane_seg[l]] || mask_r[s][bus.lane_seg[l]]) begin
                            dup_s = 1'b1;
                        end else begin
                            dup_s = dup_s;
                        end
                        wr_mask_s[s][bus.lane_seg[l]] = 1'b1;
                        wr_data_s[s][bus.lane_seg[l]] = bus.lane_data[l];
                        wr_txnid_s[s]                 = bus.lane_txnid[l];
                    end
                end else begin
                    wr_mask_s[s] = wr_mask_s[s];
                end
            end
        end
    end

    // Fixed-priority push arbiter: lowest-index completed slot goes first
    always_comb begin
        push_hit_s = 1'b0;
        push_idx_s = '0;
        for (int s = ENTRIES - 1; s >= 0; s--) begin
            if (state_r[s] == S_DONE) begin
                push_hit_s = 1'b1;
                push_idx_s = IDX_W'(s);
            end else begin
                push_hit_s = push_hit_s;
            end
        end
    end

    // FIFO handshake; a full FIFO still accepts a push when it pops the same cycle
    always_comb begin
        fifo_full_s = (count_r == (PTR_W + 1)'(OUT_DEPTH));
        pop_s       = (count_r != '0) && bus.out_rdy;
        push_s      = push_hit_s && (!fifo_full_s || pop_s);
    end

    // Slot FSMs, output FIFO and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < ENTRIES; s++) begin
                state_r[s] <= S_IDLE;
                mask_r[s]  <= 8'h00;
                data_r[s]  <= '0;
                txnid_r[s] <= '0;
            end
            for (int e = 0; e < OUT_DEPTH; e++) begin
                fifo_data_r[e]  <= '0;
                fifo_txnid_r[e] <= '0;
            end
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            err_dup_r  <= 1'b0;
            err_busy_r <= 1'b0;
        end else begin
            for (int s = 0; s < ENTRIES; s++) begin
                if (push_s && (push_idx_s == IDX_W'(s))) begin
                    // Released on the push edge; lanes may reuse it next cycle
                    state_r[s] <= S_IDLE;
                    mask_r[s]  <= 8'h00;
                end else begin
                    case (state_r[s])
                        S_IDLE, S_FILL: begin
                            mask_r[s]  <= mask_r[s] | wr_mask_s[s];
                            data_r[s]  <= wr_data_s[s];
                            txnid_r[s] <= wr_txnid_s[s];
                            if ((mask_r[s] | wr_mask_s[s]) == 8'hFF) begin
                                state_r[s] <= S_DONE;
                            end else if ((mask_r[s] | wr_mask_s[s]) != 8'h00) begin
                                state_r[s] <= S_FILL;
                            end else begin
                                state_r[s] <= S_IDLE;
                            end
                        end
                        S_DONE: begin
                            state_r[s] <= S_DONE;
                        end
                        default: begin
                            state_r[s] <= S_IDLE;
                            mask_r[s]  <= 8'h00;
                        end
                    endcase
                end
            end

            if (push_s) begin
                fifo_data_r[wr_ptr_r]  <= data_r[push_idx_s];
                fifo_txnid_r[wr_ptr_r] <= txnid_r[push_idx_s];
                wr_ptr_r               <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase

            err_dup_r  <= err_dup_r  | dup_s;
            err_busy_r <= err_busy_r | busy_hit_s;
        end
    end

    // Slot occupancy view
    always_comb begin
        for (int s = 0; s < ENTRIES; s++) begin
            slot_busy[s] = (state_r[s] != S_IDLE);
        end
    end

    assign bus.out_vld   = (count_r != '0);
    assign bus.out_data  = fifo_data_r[rd_ptr_r];
    assign bus.out_txnid = fifo_txnid_r[rd_ptr_r];
    assign err_dup       = err_dup_r;
    assign err_busy      = err_busy_r;
endmodule

// File: tb/tb_rd_line_collector.sv
// tb_rd_line_collector
//   Scoreboard bench for rd_line_collector: expected lines are queued when the
//   completing stimulus is driven and compared as the DUT hands lines out.
module tb_rd_line_collector;
    logic       clk;
    logic       rst;
    logic [7:0] slot_busy;
    logic       err_dup;
    logic       err_busy;

    int n_vec = 0;
    int n_err = 0;
    int n_rx  = 0;

    typedef struct packed {
        logic [7:0]   tid;
        logic [255:0] data;
    } exp_t;

    exp_t sb_q[$];

    rd_line_collector_if #(.TXNID_W(8)) bus ();

    rd_line_collector #(
        .ENTRIES   (8),
        .TXNID_W   (8),
        .OUT_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .slot_busy (slot_busy),
        .err_dup   (err_dup),
        .err_busy  (err_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mkline(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) begin
            l[32*k +: 32] = base + 32'(k);
        end
        return l;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_lanes();
        bus.lane_vld   = '0;
        bus.lane_data  = '0;
        bus.lane_txnid = '0;
        bus.lane_seg   = '0;
    endtask

    task automatic wr(input int l, input logic [7:0] tid, input logic [2:0] seg, input logic [31:0] d);
        bus.lane_vld[l]   = 1'b1;
        bus.lane_txnid[l] = tid;
        bus.lane_seg[l]   = seg;
        bus.lane_data[l]  = d;
    endtask

    task automatic expect_line(input logic [7:0] tid, input logic [255:0] data);
        exp_t e;
        e.tid  = tid;
        e.data = data;
        sb_q.push_back(e);
    endtask

    // All 8 segments of one line in a single cycle, segment k = base + k
    task automatic full_line(input logic [7:0] tid, input logic [31:0] base, input bit expect_it);
        for (int k = 0; k < 8; k++) begin
            wr(k, tid, 3'(k), base + 32'(k));
        end
        if (expect_it) begin
            expect_line(tid, mkline(base));
        end
    endtask

    task automatic wait_rx(input int target, input int budget);
        for (int i = 0; i < budget && n_rx < target; i++) begin
            step();
        end
        chk("rx_count", 256'(n_rx), 256'(target));
    endtask

    // Output monitor: every handed-out line must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_vld && bus.out_rdy) begin
            chk("sb_nonempty", 256'(sb_q.size() != 0), 256'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("line_tid", 256'(bus.out_txnid), 256'(e.tid));
                chk("line_data", bus.out_data, e.data);
            end
            n_rx++;
        end
    end

    initial begin
        exp_t e5;
        int   rx0;

        rst = 1'b1;
        bus.out_rdy = 1'b0;
        idle_lanes();
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        chk("rst_out_vld", 256'(bus.out_vld), 256'd0);
        chk("rst_out_data", bus.out_data, 256'd0);
        chk("rst_out_txnid", 256'(bus.out_txnid), 256'd0);
        chk("rst_slot_busy", 256'(slot_busy), 256'd0);
        chk("rst_err_dup", 256'(err_dup), 256'd0);
        chk("rst_err_busy", 256'(err_busy), 256'd0);

        // T1: whole line in one cycle, out_vld two cycles later
        bus.out_rdy = 1'b1;
        full_line(8'd3, 32'h0000_1000, 1'b1);
        step();
        idle_lanes();
        chk("t1_vld_n1", 256'(bus.out_vld), 256'd0);
        chk("t1_busy_n1", 256'(slot_busy[3]), 256'd1);
        step();
        chk("t1_vld_n2", 256'(bus.out_vld), 256'd1);
        chk("t1_tid_n2", 256'(bus.out_txnid), 256'd3);
        chk("t1_busy_n2", 256'(slot_busy[3]), 256'd0);
        step();
        chk("t1_drained", 256'(bus.out_vld), 256'd0);

        // T2: txnid 5 spread over four cycles, out of order
        expect_line(8'd5, mkline(32'h5A00_0000));
        chk("t2_busy_pre", 256'(slot_busy[5]), 256'd0);
        wr(0, 8'd5, 3'd6, 32'h5A00_0006);
        wr(3, 8'd5, 3'd1, 32'h5A00_0001);
        step();
        idle_lanes();
        chk("t2_busy_first", 256'(slot_busy[5]), 256'd1);
        wr(1, 8'd5, 3'd3, 32'h5A00_0003);
        wr(7, 8'd5, 3'd0, 32'h5A00_0000);
        step();
        idle_lanes();
        wr(2, 8'd5, 3'd7, 32'h5A00_0007);
        wr(4, 8'd5, 3'd4, 32'h5A00_0004);
        step();
        idle_lanes();
        chk("t2_vld_partial", 256'(bus.out_vld), 256'd0);
        wr(5, 8'd5, 3'd2, 32'h5A00_0002);
        wr(6, 8'd5, 3'd5, 32'h5A00_0005);
        step();
        idle_lanes();
        chk("t2_vld_n1", 256'(bus.out_vld), 256'd0);
        chk("t2_busy_n1", 256'(slot_busy[5]), 256'd1);
        step();
        chk("t2_vld_n2", 256'(bus.out_vld), 256'd1);
        chk("t2_tid_n2", 256'(bus.out_txnid), 256'd5);
        chk("t2_busy_n2", 256'(slot_busy[5]), 256'd0);
        step();

        // T3: slots 1 and 2 complete on the same edge
        expect_line(8'd1, mkline(32'h0100_0000));
        expect_line(8'd2, mkline(32'h0200_0000));
        for (int k = 0; k < 7; k++) wr(k, 8'd1, 3'(k), 32'h0100_0000 + 32'(k));
        step();
        idle_lanes();
        for (int k = 0; k < 7; k++) wr(k, 8'd2, 3'(k), 32'h0200_0000 + 32'(k));
        step();
        idle_lanes();
        wr(0, 8'd1, 3'd7, 32'h0100_0007);
        wr(1, 8'd2, 3'd7, 32'h0200_0007);
        step();
        idle_lanes();
        chk("t3_vld_n1", 256'(bus.out_vld), 256'd0);
        chk("t3_busy_n1", 256'(slot_busy[2:1]), 256'd3);
        step();
        chk("t3_tid_first", 256'(bus.out_txnid), 256'd1);
        chk("t3_slot2_waits", 256'(slot_busy[2:1]), 256'd2);
        step();
        chk("t3_vld_second", 256'(bus.out_vld), 256'd1);
        chk("t3_tid_second", 256'(bus.out_txnid), 256'd2);
        step();
        chk("t3_drained", 256'(bus.out_vld), 256'd0);

        // T4: consumer stalled, six lines against a 4-deep FIFO
        bus.out_rdy = 1'b0;
        rx0 = n_rx;
        for (int i = 0; i < 6; i++) begin
            full_line(8'h10 + 8'(i), 32'h3000_0000 | (32'(i) << 16), 1'b1);
            step();
            idle_lanes();
        end
        repeat (3) step();
        chk("t4_vld_stall", 256'(bus.out_vld), 256'd1);
        chk("t4_tid_head", 256'(bus.out_txnid), 256'h10);
        chk("t4_busy_waiting", 256'(slot_busy), 256'h30);
        step();
        chk("t4_tid_hold", 256'(bus.out_txnid), 256'h10);
        chk("t4_data_hold", bus.out_data, mkline(32'h3000_0000));
        bus.out_rdy = 1'b1;
        wait_rx(rx0 + 6, 40);
        chk("t4_busy_after", 256'(slot_busy), 256'd0);

        // T5: lanes 2 and 6 both write seg 4 of txnid 0
        chk("t5_dup_pre", 256'(err_dup), 256'd0);
        rx0 = n_rx;
        e5.tid  = 8'd0;
        e5.data = mkline(32'h5000_0000);
        e5.data[32*4 +: 32] = 32'h6666_6666;
        sb_q.push_back(e5);
        wr(0, 8'd0, 3'd0, 32'h5000_0000);
        wr(1, 8'd0, 3'd1, 32'h5000_0001);
        wr(2, 8'd0, 3'd4, 32'h2222_2222);
        wr(3, 8'd0, 3'd2, 32'h5000_0002);
        wr(4, 8'd0, 3'd3, 32'h5000_0003);
        wr(5, 8'd0, 3'd5, 32'h5000_0005);
        wr(6, 8'd0, 3'd4, 32'h6666_6666);
        wr(7, 8'd0, 3'd6, 32'h5000_0006);
        step();
        idle_lanes();
        chk("t5_dup_set", 256'(err_dup), 256'd1);
        wr(0, 8'd0, 3'd7, 32'h5000_0007);
        step();
        idle_lanes();
        wait_rx(rx0 + 1, 20);
        chk("t5_dup_sticky", 256'(err_dup), 256'd1);

        // T6: write to a completed slot is dropped
        chk("t6_busy_pre", 256'(err_busy), 256'd0);
        rx0 = n_rx;
        full_line(8'd7, 32'h7000_0000, 1'b1);
        step();
        idle_lanes();
        wr(3, 8'd7, 3'd3, 32'hDEAD_BEEF);
        step();
        idle_lanes();
        chk("t6_err_busy", 256'(err_busy), 256'd1);
        chk("t6_slot_free", 256'(slot_busy[7]), 256'd0);
        wait_rx(rx0 + 1, 20);
        chk("t6_busy_sticky", 256'(err_busy), 256'd1);

        // Reset mid-operation: queued line and partial slot vanish
        bus.out_rdy = 1'b0;
        full_line(8'd6, 32'h6000_0000, 1'b0);
        step();
        idle_lanes();
        wr(0, 8'd4, 3'd0, 32'h4000_0000);
        wr(1, 8'd4, 3'd1, 32'h4000_0001);
        step();
        idle_lanes();
        step();
        chk("rst_mid_vld_pre", 256'(bus.out_vld), 256'd1);
        chk("rst_mid_busy_pre", 256'(slot_busy), 256'h10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_busy", 256'(slot_busy), 256'd0);
        chk("rst_mid_vld", 256'(bus.out_vld), 256'd0);
        chk("rst_mid_err_dup", 256'(err_dup), 256'd0);
        chk("rst_mid_err_busy", 256'(err_busy), 256'd0);
        rx0 = n_rx;
        bus.out_rdy = 1'b1;
        repeat (5) step();
        chk("rst_mid_no_output", 256'(n_rx), 256'(rx0));
        chk("sb_empty_end", 256'(sb_q.size()), 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
